// File: rtl/sqrt_ctrl_fsm_pkg.sv
// sqrt_ctrl_fsm_pkg: shared state encodings, iteration limits and mux selects for the sqrt controller
package sqrt_ctrl_fsm_pkg;

    // 256 iterations is never reached legally: floor(sqrt(65535)) = 255
    localparam int MAX_ITER_DEF = 256;
    localparam int ITER_W_DEF   = 9;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BOOT = 3'd1;
    localparam logic [2:0] ST_TEST = 3'd2;
    localparam logic [2:0] ST_INC  = 3'd3;
    localparam logic [2:0] ST_ADD  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_BOOT = ST_BOOT,
        S_TEST = ST_TEST,
        S_INC  = ST_INC,
        S_ADD  = ST_ADD,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } state_e;

    // adder operand select in the DataPath
    localparam logic MUX_ROOT   = 1'b0;
    localparam logic MUX_SQUARE = 1'b1;

endpackage

// File: rtl/sqrt_ctrl_fsm_if.sv
// sqrt_ctrl_fsm_if: start request, DataPath flag and control strobes between the FSM and its neighbours
interface sqrt_ctrl_fsm_if;
    logic start_i;
    logic N_o;
    logic boot_o;
    logic wr_square_o;
    logic wr_root_o;
    logic muxes_o;
    logic busy_o;
    logic done_o;
    logic err_o;

    // requester + DataPath side
    modport master (
        output start_i, N_o,
        input  boot_o, wr_square_o, wr_root_o, muxes_o, busy_o, done_o, err_o
    );

    // controller side
    modport slave (
        input  start_i, N_o,
        output boot_o, wr_square_o, wr_root_o, muxes_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/sqrt_ctrl_fsm_iter_counter.sv
// sqrt_ctrl_fsm_iter_counter: saturating iteration counter with terminal-count flag at MAX_ITER
module sqrt_ctrl_fsm_iter_counter #(
    parameter int MAX_ITER = 256,
    parameter int ITER_W   = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    logic [ITER_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == ITER_W'(MAX_ITER));

    // clear wins; increment stops at MAX_ITER so the count never wraps
    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sqrt_ctrl_fsm.sv
// sqrt_ctrl_fsm: sequences boot / root-increment / square-accumulate on the sqrt DataPath until square > valor
module sqrt_ctrl_fsm
    import sqrt_ctrl_fsm_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_W   = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_ctrl_fsm_if.slave    bus
);
    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   clr, tc;

    sqrt_ctrl_fsm_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (state_q == S_INC),
        .tc_o  (tc)
    );

    // next state; err is set on the way into ERR and held until a start is accepted
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_BOOT;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            S_BOOT: state_d = S_TEST;
            S_TEST: begin
                state_d = bus.N_o ? S_DONE : tc ? S_ERR : S_INC;
                err_d   = err_q | (!bus.N_o && tc);
            end
            S_INC:   state_d = S_ADD;
            S_ADD:   state_d = S_TEST;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs decoded from the registered state only
    always_comb begin
        bus.boot_o      = (state_q == S_BOOT);
        bus.wr_square_o = (state_q == S_BOOT) || (state_q == S_ADD);
        bus.wr_root_o   = (state_q == S_BOOT) || (state_q == S_INC);
        bus.muxes_o     = (state_q == S_ADD) ? MUX_SQUARE : MUX_ROOT;
        bus.busy_o      = (state_q == S_BOOT) || (state_q == S_TEST) ||
                          (state_q == S_INC)  || (state_q == S_ADD);
        bus.done_o      = (state_q == S_DONE);
        bus.err_o       = err_q;
    end
endmodule

// File: doc/sqrt_ctrl_fsm.md
Name: sqrt_ctrl_fsm

Overview:
Control unit for the integer square-root DataPath (square/root registers, shared adder, comparison flag N_o). It accepts a start request and sequences boot, root-increment and square-accumulate steps until N_o reports square > valor, then signals done. It also supervises the iteration count and flags a runaway loop. It instantiates next to DataPath inside the square-root top level.

Parameters:
MAX_ITER, 256, iterations allowed before an overflow error (floor(sqrt(65535)) = 255, so 256 is never legally reached).
ITER_W, 9, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request a new root computation; sampled only in IDLE
N_o  in  1  DataPath flag: 1 when (valor - square) < 0, combinational from registered square
boot_o  out  1  to DataPath boot_i: selects SQUARE_INIT/ROOT_INIT in both muxes
wr_square_o  out  1  to DataPath wr_square_i
wr_root_o  out  1  to DataPath wr_root_i
muxes_o  out  1  to DataPath muxes_i: 0 = adder computes root+1, 1 = adder computes square+2*root+1
busy_o  out  1  high from BOOT through TEST/INC/ADD; low in IDLE, DONE, ERR
done_o  out  1  one-cycle pulse; root_o in DataPath is valid from this cycle until the next start
err_o  out  1  sticky overflow flag; cleared by the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, iteration counter=0; all outputs 0. Reset mid-computation aborts immediately; no done_o pulse.
- States: IDLE, BOOT, TEST, INC, ADD, DONE, ERR. All outputs are Moore and registered-state decoded; no output depends combinationally on start_i.
- IDLE: outputs 0. start_i=1 -> BOOT, clear err_o and counter.
- BOOT: boot_o=wr_square_o=wr_root_o=1 (square<=1, root<=0). -> TEST.
- TEST: all write strobes 0; N_o is stable. N_o=1 -> DONE. N_o=0 and counter==MAX_ITER -> ERR. N_o=0 otherwise -> INC.
- INC: wr_root_o=1, muxes_o=0 (root<=root+1); counter<=counter+1. -> ADD.
- ADD: wr_square_o=1, muxes_o=1 (square<=square+2*root+1 with the already-incremented root, i.e. square=(root+1)^2). -> TEST.
- DONE: done_o=1 for exactly one cycle. -> IDLE. start_i in DONE is ignored.
- ERR: err_o=1, busy_o=0. -> IDLE next cycle; err_o stays high until the next start is accepted.
- start_i while busy_o=1 is ignored (no restart, no queueing).
- valor_i is not latched; upstream holds it stable while busy_o=1.
- Latency: for r=floor(sqrt(valor)), a start sampled at edge k gives done_o high during cycle k+3r+3. Iterations = r; counter never exceeds 255 for 16-bit valor.
- Counter saturates at MAX_ITER and never wraps.

Decomposition:
- Shared package/include sqrt_pkg: state encodings (3-bit localparams ST_IDLE..ST_ERR), MAX_ITER default, mux select constants MUX_ROOT=0, MUX_SQUARE=1.
- One natural sub-module: sqrt_iter_counter (ITER_W-bit, clear/increment/saturate, terminal-count output eq MAX_ITER). The FSM stays in sqrt_ctrl_fsm.

Test Plan:
- Reset with start_i=1 held -> all outputs 0, state IDLE; on release, start accepted at the first edge, boot_o=1 the next cycle.
- valor=0 with DataPath model, start at edge k -> BOOT, TEST sees N_o=1, done_o pulse at k+3, root=0, no INC/ADD strobes.
- valor=16 -> 4 INC/ADD pairs with muxes_o alternating 0/1; done_o at k+15; root=4, square=25.
- valor=65535 -> 255 iterations, done_o at k+768, root=255, err_o=0; start_i pulses during busy_o are ignored.
- Faulty model forcing N_o=0 permanently -> after 256 INC cycles, ERR, err_o=1, busy_o=0, no done_o; next start clears err_o.
- rst_n asserted during ADD of valor=100 -> outputs 0 asynchronously; new start after release gives done_o at k+33 with root=10.
